// File: rtl/latch_pkg.sv
// Shared types for the latch reader path: FSM state encoding and the
// minimum synchroniser depth that every sync_chain instance enforces.
package latch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    UPDATE
  } state_e;

  localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous bus; every stage resets to 0.
// Depth is clamped to MIN_SYNC_STAGES so a bad override cannot drop to one flop.
module sync_chain
  import latch_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  localparam int unsigned DEPTH_EFF = (DEPTH < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : DEPTH;

  logic [DEPTH_EFF-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH_EFF-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d[0] = d_in;
    for (int unsigned i = 1; i < DEPTH_EFF; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: the whole stage array is reset, not just the output flop, so a
  // stale pre-reset value can never ripple out after rst_n is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes its neighbour's pre-edge value.
      stage_q <= stage_d;
    end
  end

  assign d_out = stage_q[DEPTH_EFF-1];

endmodule

// File: rtl/latch_q_sampler.sv
// Synchronises a latch bank's q/enable into clk and accepts a new word only
// after it has been stable with the latch closed; each acceptance pulses q_valid.
module latch_q_sampler
  import latch_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] latch_q,
  input  logic             latch_ena,
  output logic [WIDTH-1:0] q_out,
  output logic             q_valid,
  output logic             busy,
  output logic [7:0]       change_cnt
);

  localparam int unsigned    CNT_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] samp;
  logic             ena_s;

  sync_chain #(.WIDTH(WIDTH), .DEPTH(SYNC_STAGES)) u_sync_data (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (latch_q),
    .d_out(samp)
  );

  sync_chain #(.WIDTH(1), .DEPTH(SYNC_STAGES)) u_sync_ena (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (latch_ena),
    .d_out(ena_s)
  );

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] samp_prev_q,  samp_prev_d;
  logic [WIDTH-1:0] cand_q,       cand_d;
  logic [WIDTH-1:0] q_out_q,      q_out_d;
  logic             q_valid_q,    q_valid_d;
  logic [7:0]       change_cnt_q, change_cnt_d;

  always_comb begin
    // NOTE: every output gets a default first, so no branch can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    samp_prev_d  = samp;
    cand_d       = cand_q;
    q_out_d      = q_out_q;
    q_valid_d    = 1'b0;
    change_cnt_d = change_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (samp != q_out_q || ena_s) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        // Any movement or an open latch restarts the stability window.
        if (ena_s || samp != samp_prev_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cand_d  = samp;
          state_d = (samp != q_out_q) ? UPDATE : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UPDATE: begin
        q_out_d      = cand_q;
        q_valid_d    = 1'b1;
        change_cnt_d = change_cnt_q + 8'd1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      samp_prev_q  <= '0;
      cand_q       <= '0;
      q_out_q      <= '0;
      q_valid_q    <= 1'b0;
      change_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      samp_prev_q  <= samp_prev_d;
      cand_q       <= cand_d;
      q_out_q      <= q_out_d;
      q_valid_q    <= q_valid_d;
      change_cnt_q <= change_cnt_d;
    end
  end

  assign q_out      = q_out_q;
  assign q_valid    = q_valid_q;
  assign busy       = (state_q != IDLE);
  assign change_cnt = change_cnt_q;

endmodule

// File: doc/latch_q_sampler.md
Name: latch_q_sampler

Overview:
Reader side of the transparent D-latch storage path. Takes the asynchronous q output of a latch bank and its enable, and synchronises them into the clk domain. The captured value is accepted only after it has been stable for a programmable number of cycles with the latch closed. Each accepted change is announced with a one-cycle valid pulse, so downstream logic never samples a transparent or settling latch.

Parameters:
WIDTH, 8, bit width of latch_q / q_out
SYNC_STAGES, 2, synchroniser flops per input bit (minimum 2)
STABLE_CYCLES, 4, consecutive equal samples with latch closed required to accept (minimum 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
latch_q  input  WIDTH  latch output, asynchronous to clk
latch_ena  input  1  latch enable, asynchronous; 1 = transparent
q_out  output  WIDTH  last accepted stable value
q_valid  output  1  one-cycle pulse when q_out is updated
busy  output  1  high whenever state is not IDLE
change_cnt  output  8  count of q_valid pulses, wraps 255->0

Behaviour:
- Reset (rst_n=0, asynchronous): all synchroniser flops, samp_d, cand, cnt, q_out, q_valid and change_cnt go to 0; state=IDLE. Release is synchronous in effect: the first active edge after deassertion runs normally.
- Synchronisers: latch_q and latch_ena each pass through SYNC_STAGES flops. samp = last data stage, ena_s = last enable stage. samp_d = samp delayed one cycle.
- cnt width: clog2(STABLE_CYCLES)+1.
- FSM states: IDLE, SETTLE, UPDATE.
- IDLE:
  - If samp != q_out or ena_s=1: go to SETTLE, cnt<=0.
  - Otherwise stay.
- SETTLE:
  - If ena_s=1 or samp != samp_d: cnt<=0, stay.
  - Else if cnt == STABLE_CYCLES-1: cand<=samp, then go to UPDATE if samp != q_out, else go to IDLE with no pulse (glitch rejected).
  - Else cnt<=cnt+1.
- UPDATE: q_out<=cand, q_valid<=1 (registered, high exactly one cycle), change_cnt<=change_cnt+1, go to IDLE.
- q_valid is 0 in every other cycle.
- Latency: a latch_q change with latch_ena low, meeting setup before edge 1, appears on q_out/q_valid after edge SYNC_STAGES+STABLE_CYCLES+2 (8 with defaults).
- latch_ena high at any time while in SETTLE restarts the count. An output can never be produced while the latch is transparent.
- Data changing during UPDATE is not lost: IDLE re-detects it on the next cycle.
- Reset mid-SETTLE or mid-UPDATE aborts with no pulse; q_out returns to 0.
- Inputs are treated as multi-bit asynchronous. The stability window guarantees a coherent word even if individual bits resolve in different cycles.

Decomposition:
- Shared package latch_pkg: state enum (IDLE, SETTLE, UPDATE) and the constant MIN_SYNC_STAGES=2.
- One sub-module, sync_chain: parameterised width and depth, async active-low reset to 0. Instantiated twice, for data and for enable.

Test Plan:
1. Reset: rst_n=0 with latch_q=8'hA5 -> q_out=0, q_valid=0, busy=0, change_cnt=0; with rst_n held low, outputs stay 0 for 20 cycles.
2. Clean load: latch_ena=0, latch_q 00->3C one cycle before edge 1 -> q_out=3C and q_valid=1 for exactly one cycle after edge 8; change_cnt=1.
3. Transparent hold-off: latch_ena=1 for 10 cycles while latch_q toggles 11/22, then latch_ena=0 with latch_q=22 -> single q_valid, q_out=22, no pulse during the transparent window.
4. Glitch reject: with q_out=22, latch_q pulses to 23 for 2 cycles then returns to 22 -> busy rises, no q_valid, q_out stays 22, change_cnt unchanged.
5. Reset mid-operation: start a 22->7F change, assert rst_n=0 while busy=1 -> immediate q_out=0, no pulse. After release with latch_q=7F, q_out=7F after 8 edges.
6. Counter wrap: 256 accepted distinct changes -> change_cnt returns to 0, with exactly 256 q_valid pulses observed.
